bp_branch_predictor: RTL and testbench

- Parametrised fetch-stage branch predictor for the 5-stage RV32I pipeline: direct-mapped BTB with a 2-bit saturating counter per entry.
- Replaces the current "always predict PC+4, flush on every taken branch/jump" policy.
- IF stage looks up the predicted next PC in the same cycle; EX stage resolves the actual outcome, trains the table and raises mispredict with the redirect PC.
- Also holds saturating statistics counters for the debug bench.

---
 rtl/bp_branch_predictor_if.sv | 36 +++
 rtl/bp_branch_predictor.sv | 125 ++++++++++++
 tb/tb_bp_branch_predictor.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/bp_branch_predictor_if.sv
// Fetch/execute-side signal bundle of the BTB branch predictor.
// master = pipeline, slave = predictor.
interface bp_branch_predictor_if #(
    parameter int PC_W = 9
);
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_next_pc;
    logic            flush_all;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic            ex_is_branch;
    logic            ex_is_jump;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_target;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output if_pc, flush_all, ex_valid, ex_pc,
        output ex_is_branch, ex_is_jump, ex_taken,
        output ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_next_pc,
        input  mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, flush_all, ex_valid, ex_pc,
        input  ex_is_branch, ex_is_jump, ex_taken,
        input  ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_next_pc,
        output mispredict, redirect_pc
    );
endinterface

// File: rtl/bp_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: same-cycle IF
// lookup, EX-stage training/redirect, and saturating statistics.
module bp_branch_predictor #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    bp_branch_predictor_if.slave bp,
    output logic [CNT_W-1:0]     ctrl_count,
    output logic [CNT_W-1:0]     mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][PC_W-1:0]  tgt_q, tgt_d;
    logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;
    logic [ENTRIES-1:0]            jmp_q, jmp_d;
    logic [CNT_W-1:0]              ctrl_cnt_q, ctrl_cnt_d;
    logic [CNT_W-1:0]              mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit, ex_ctrl;
    logic [PC_W-1:0]  if_seq, ex_seq;
    logic [PC_W-1:0]  actual_pc, predicted_pc;
    logic             upd_hit, upd_alloc, upd_inval;
    logic [1:0]       ctr_inc, ctr_dec;

    always_comb begin
        if_idx = bp.if_pc[IDX_W+1:2];
        if_tag = bp.if_pc[PC_W-1:IDX_W+2];
        if_seq = bp.if_pc + PC_W'(4);
        if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

        bp.pred_taken   = if_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);
        bp.pred_next_pc = bp.pred_taken ? tgt_q[if_idx] : if_seq;
    end

    always_comb begin
        ex_idx  = bp.ex_pc[IDX_W+1:2];
        ex_tag  = bp.ex_pc[PC_W-1:IDX_W+2];
        ex_seq  = bp.ex_pc + PC_W'(4);
        ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        ex_ctrl = bp.ex_is_branch || bp.ex_is_jump;

        actual_pc    = bp.ex_taken ? bp.ex_target : ex_seq;
        predicted_pc = bp.ex_pred_taken ? bp.ex_pred_target : ex_seq;

        bp.mispredict  = !reset && bp.ex_valid
                       && (actual_pc != predicted_pc);
        bp.redirect_pc = actual_pc;

        upd_hit   = bp.ex_valid && ex_ctrl && ex_hit;
        upd_alloc = bp.ex_valid && ex_ctrl && !ex_hit && bp.ex_taken;
        upd_inval = bp.ex_valid && !ex_ctrl && ex_hit;

        ctr_inc = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
        ctr_dec = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        ctr_d   = ctr_q;
        jmp_d   = jmp_q;

        unique case (1'b1)
            upd_hit: begin
                ctr_d[ex_idx] = bp.ex_taken ? ctr_inc : ctr_dec;
                jmp_d[ex_idx] = bp.ex_is_jump;
                if (bp.ex_taken) tgt_d[ex_idx] = bp.ex_target;
            end
            upd_alloc: begin
                valid_d[ex_idx] = 1'b1;
                tag_d[ex_idx]   = ex_tag;
                tgt_d[ex_idx]   = bp.ex_target;
                ctr_d[ex_idx]   = 2'b10;
                jmp_d[ex_idx]   = bp.ex_is_jump;
            end
            upd_inval: valid_d[ex_idx] = 1'b0;
            default: ;
        endcase

        // fence.i overrides any same-cycle allocation
        if (bp.flush_all) valid_d = '0;
    end

    always_comb begin
        ctrl_cnt_d = ctrl_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        if (bp.ex_valid && ex_ctrl && !(&ctrl_cnt_q))
            ctrl_cnt_d = ctrl_cnt_q + CNT_W'(1);
        if (bp.mispredict && !(&mis_cnt_q))
            mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            ctr_q      <= '0;
            ctrl_cnt_q <= '0;
            mis_cnt_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            ctr_q      <= ctr_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    // Payload fields only matter once valid is set
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        tgt_q <= tgt_d;
        jmp_q <= jmp_d;
    end

    assign ctrl_count       = ctrl_cnt_q;
    assign mispredict_count = mis_cnt_q;
endmodule

// File: tb/tb_bp_branch_predictor.sv
// Directed bench for bp_branch_predictor; a second instance with
// 2-bit statistics counters checks saturation.
module tb_bp_branch_predictor;
    localparam int PC_W = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic [PC_W-1:0] if_pc, ex_pc, ex_target, ex_pred_target;
    logic            flush_all, ex_valid, ex_is_branch, ex_is_jump;
    logic            ex_taken, ex_pred_taken;
    logic [15:0]     ctrl_count, mispredict_count;
    logic [1:0]      ctrl_count_s, mispredict_count_s;
    int              n_tests = 0;
    int              n_fail  = 0;

    always #5 clk = ~clk;

    bp_branch_predictor_if #(.PC_W(PC_W)) aif ();
    bp_branch_predictor_if #(.PC_W(PC_W)) bif ();

    assign aif.if_pc          = if_pc;
    assign aif.flush_all      = flush_all;
    assign aif.ex_valid       = ex_valid;
    assign aif.ex_pc          = ex_pc;
    assign aif.ex_is_branch   = ex_is_branch;
    assign aif.ex_is_jump     = ex_is_jump;
    assign aif.ex_taken       = ex_taken;
    assign aif.ex_target      = ex_target;
    assign aif.ex_pred_taken  = ex_pred_taken;
    assign aif.ex_pred_target = ex_pred_target;

    assign bif.if_pc          = if_pc;
    assign bif.flush_all      = flush_all;
    assign bif.ex_valid       = ex_valid;
    assign bif.ex_pc          = ex_pc;
    assign bif.ex_is_branch   = ex_is_branch;
    assign bif.ex_is_jump     = ex_is_jump;
    assign bif.ex_taken       = ex_taken;
    assign bif.ex_target      = ex_target;
    assign bif.ex_pred_taken  = ex_pred_taken;
    assign bif.ex_pred_target = ex_pred_target;

    bp_branch_predictor #(.PC_W(PC_W), .ENTRIES(16), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .bp               (aif.slave),
        .ctrl_count       (ctrl_count),
        .mispredict_count (mispredict_count)
    );

    bp_branch_predictor #(.PC_W(PC_W), .ENTRIES(16), .CNT_W(2)) dut_s (
        .clk              (clk),
        .reset            (reset),
        .bp               (bif.slave),
        .ctrl_count       (ctrl_count_s),
        .mispredict_count (mispredict_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid       = 1'b0;
        ex_pc          = '0;
        ex_is_branch   = 1'b0;
        ex_is_jump     = 1'b0;
        ex_taken       = 1'b0;
        ex_target      = '0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = '0;
    endtask

    task automatic ex_set(input logic br, input logic jp, input logic tk,
                          input logic [8:0] pc, input logic [8:0] tgt,
                          input logic ptk, input logic [8:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_branch   = br;
        ex_is_jump     = jp;
        ex_taken       = tk;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic lookup(input string tag, input logic [8:0] pc,
                          input logic tk, input logic [8:0] nxt);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, 32'(aif.pred_taken), 32'(tk));
        check({tag, "_next"}, 32'(aif.pred_next_pc), 32'(nxt));
    endtask

    task automatic mis(input string tag, input logic m,
                       input logic [8:0] rpc);
        #1;
        check({tag, "_mis"}, 32'(aif.mispredict), 32'(m));
        if (m) check({tag, "_redir"}, 32'(aif.redirect_pc), 32'(rpc));
    endtask

    task automatic counts(input string tag, input int c, input int m);
        check({tag, "_ctrl"}, 32'(ctrl_count), 32'(c));
        check({tag, "_miscnt"}, 32'(mispredict_count), 32'(m));
    endtask

    initial begin
        reset     = 1'b1;
        flush_all = 1'b0;
        if_pc     = '0;
        ex_idle();
        tick();
        tick();
        reset = 1'b0;

        lookup("rst", 9'h040, 1'b0, 9'h044);
        mis("rst", 1'b0, 9'h000);
        counts("rst", 0, 0);

        // First taken branch allocates; same-cycle lookup sees old entry
        ex_set(1'b1, 1'b0, 1'b1, 9'h040, 9'h010, 1'b0, 9'h044);
        mis("t1", 1'b1, 9'h010);
        lookup("t1_rbw", 9'h040, 1'b0, 9'h044);
        tick();
        ex_idle();
        lookup("t1_train", 9'h040, 1'b1, 9'h010);
        counts("t1", 1, 1);

        // Three not-taken: ctr 2->1->0->0
        ex_set(1'b1, 1'b0, 1'b0, 9'h040, 9'h010, 1'b1, 9'h010);
        mis("nt1", 1'b1, 9'h044);
        tick();
        ex_idle();
        lookup("nt1", 9'h040, 1'b0, 9'h044);
        ex_set(1'b1, 1'b0, 1'b0, 9'h040, 9'h010, 1'b0, 9'h044);
        mis("nt2", 1'b0, 9'h000);
        tick();
        ex_set(1'b1, 1'b0, 1'b0, 9'h040, 9'h010, 1'b0, 9'h044);
        mis("nt3", 1'b0, 9'h000);
        tick();
        ex_idle();
        lookup("nt3", 9'h040, 1'b0, 9'h044);
        counts("nt3", 4, 2);

        // One taken from ctr=0 reaches 1: still predicts not taken
        ex_set(1'b1, 1'b0, 1'b1, 9'h040, 9'h010, 1'b0, 9'h044);
        mis("sat0", 1'b1, 9'h010);
        tick();
        ex_idle();
        lookup("sat0", 9'h040, 1'b0, 9'h044);
        counts("sat0", 5, 3);

        // JAL aliasing index 0 with a different tag
        ex_set(1'b0, 1'b1, 1'b1, 9'h080, 9'h100, 1'b0, 9'h084);
        mis("jal", 1'b1, 9'h100);
        tick();
        ex_idle();
        lookup("jal", 9'h080, 1'b1, 9'h100);
        lookup("alias", 9'h040, 1'b0, 9'h044);
        counts("jal", 6, 4);
        check("sat_ctrl", 32'(ctrl_count_s), 32'd3);
        check("sat_mis", 32'(mispredict_count_s), 32'd3);

        // Non-control instruction hitting the entry invalidates it
        ex_set(1'b0, 1'b0, 1'b0, 9'h080, 9'h100, 1'b1, 9'h100);
        mis("nonctl", 1'b1, 9'h084);
        tick();
        ex_idle();
        lookup("inval", 9'h080, 1'b0, 9'h084);
        counts("nonctl", 6, 5);
        check("sat_mis2", 32'(mispredict_count_s), 32'd3);

        // flush_all beats a simultaneous allocation
        ex_set(1'b1, 1'b0, 1'b1, 9'h040, 9'h010, 1'b0, 9'h044);
        tick();
        ex_idle();
        lookup("realloc", 9'h040, 1'b1, 9'h010);
        ex_set(1'b1, 1'b0, 1'b1, 9'h0C4, 9'h020, 1'b0, 9'h0C8);
        flush_all = 1'b1;
        tick();
        ex_idle();
        flush_all = 1'b0;
        lookup("flush_a", 9'h040, 1'b0, 9'h044);
        lookup("flush_b", 9'h0C4, 1'b0, 9'h0C8);
        counts("flush", 8, 7);

        lookup("wrap", 9'h1FC, 1'b0, 9'h000);

        // ex_valid=0 ignores everything else
        ex_set(1'b1, 1'b0, 1'b1, 9'h040, 9'h030, 1'b1, 9'h100);
        ex_valid = 1'b0;
        mis("novalid", 1'b0, 9'h000);
        tick();
        ex_idle();
        lookup("novalid", 9'h040, 1'b0, 9'h044);
        counts("novalid", 8, 7);

        // Reset mid-training discards history
        ex_set(1'b1, 1'b0, 1'b1, 9'h040, 9'h010, 1'b0, 9'h044);
        tick();
        ex_idle();
        lookup("pre_rst", 9'h040, 1'b1, 9'h010);
        reset = 1'b1;
        ex_set(1'b1, 1'b0, 1'b1, 9'h040, 9'h030, 1'b0, 9'h044);
        mis("in_rst", 1'b0, 9'h000);
        tick();
        ex_idle();
        reset = 1'b0;
        lookup("post_rst", 9'h040, 1'b0, 9'h044);
        counts("post_rst", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
